// File: rtl/vector_processor_defs.sv
// Shared encodings for the vector instruction sequencer: opcodes, funct3,
// sequencer states and the vtype.vlmul / LSU mop field values.
package vector_processor_defs;

  typedef enum logic [6:0] {
    OPC_LOAD  = 7'b0000111,
    OPC_STORE = 7'b0100111,
    OPC_VEC   = 7'b1010111
  } v_opcode_e;

  typedef enum logic [2:0] {
    F3_OPIVV = 3'b000,
    F3_OPFVV = 3'b001,
    F3_OPMVV = 3'b010,
    F3_OPIVI = 3'b011,
    F3_OPIVX = 3'b100,
    F3_OPFVF = 3'b101,
    F3_OPMVX = 3'b110,
    F3_OPCFG = 3'b111
  } v_func3_e;

  typedef enum logic [2:0] {
    IDLE,
    CONFIG,
    ISSUE,
    WAIT,
    DONE
  } seq_state_e;

  localparam logic [2:0] VLMUL_M1   = 3'b000;
  localparam logic [2:0] VLMUL_M2   = 3'b001;
  localparam logic [2:0] VLMUL_M4   = 3'b010;
  localparam logic [2:0] VLMUL_M8   = 3'b011;
  localparam logic [2:0] VLMUL_RSVD = 3'b100;
  localparam logic [2:0] VLMUL_MF8  = 3'b101;
  localparam logic [2:0] VLMUL_MF4  = 3'b110;
  localparam logic [2:0] VLMUL_MF2  = 3'b111;

  localparam logic [1:0] MOP_UNIT      = 2'b00;
  localparam logic [1:0] MOP_IDX_UNORD = 2'b01;

endpackage

// File: rtl/vec_lmul_decode.sv
// Maps vtype.vlmul to the number of registers in the group and flags
// encodings that are reserved or exceed the supported group size.
module vec_lmul_decode
  import vector_processor_defs::*;
#(
  parameter int unsigned MAX_LMUL = 8,
  parameter int unsigned CNT_W    = $clog2(MAX_LMUL) + 1
) (
  input  logic [2:0]       vlmul,
  output logic [CNT_W-1:0] nregs,
  output logic             illegal
);

  logic [3:0] n_full;
  logic       rsvd;

  always_comb begin
    n_full = 4'd1;
    rsvd   = 1'b0;
    case (vlmul)
      VLMUL_M1:   n_full = 4'd1;
      VLMUL_M2:   n_full = 4'd2;
      VLMUL_M4:   n_full = 4'd4;
      VLMUL_M8:   n_full = 4'd8;
      VLMUL_RSVD: rsvd   = 1'b1;
      // fractional groups still occupy one register
      VLMUL_MF8, VLMUL_MF4, VLMUL_MF2: n_full = 4'd1;
    endcase
  end

  assign illegal = rsvd || ({28'd0, n_full} > MAX_LMUL);
  assign nregs   = n_full[CNT_W-1:0];

endmodule

// File: rtl/vec_inst_sequencer.sv
// Multi-cycle vector instruction sequencer: classifies one instruction,
// holds LSU mode controls and walks the LMUL register group issue by issue.
//
// state  | meaning
// IDLE   | ready to accept an instruction
// CONFIG | vset* CSR write strobe
// ISSUE  | start pulse for register reg_grp_idx of the group
// WAIT   | waiting for the owning unit's done pulse
// DONE   | retire pulse, back to IDLE next cycle
module vec_inst_sequencer
  import vector_processor_defs::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MAX_LMUL = 8,
  parameter int unsigned CNT_W    = $clog2(MAX_LMUL) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inst_valid,
  output logic             inst_ready,
  input  logic [XLEN-1:0]  vec_inst,
  input  logic [2:0]       vlmul,
  output logic             csrwr_en,
  output logic             ld_inst,
  output logic             st_inst,
  output logic             stride_sel,
  output logic             index_str,
  output logic             index_unordered,
  output logic             lsu_start,
  output logic             arith_start,
  output logic [CNT_W-1:0] reg_grp_idx,
  input  logic             lsu_done,
  input  logic             exec_done,
  output logic             busy,
  output logic             inst_done,
  output logic             illegal_inst
);

  seq_state_e       state;
  logic [CNT_W-1:0] last_idx;
  logic [CNT_W-1:0] nregs;
  logic             lmul_illegal;

  vec_lmul_decode #(.MAX_LMUL(MAX_LMUL), .CNT_W(CNT_W)) u_lmul (
    .vlmul   (vlmul),
    .nregs   (nregs),
    .illegal (lmul_illegal)
  );

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [1:0] mop;
  logic       is_conf, is_load, is_store, is_mem, dec_illegal, unit_done;
  logic       unused_inst_bits;

  assign opcode      = vec_inst[6:0];
  assign funct3      = vec_inst[14:12];
  assign mop         = vec_inst[27:26];
  assign is_conf     = (opcode == OPC_VEC) && (funct3 == F3_OPCFG);
  assign is_load     = (opcode == OPC_LOAD);
  assign is_store    = (opcode == OPC_STORE);
  assign is_mem      = is_load || is_store;
  assign dec_illegal = lmul_illegal || !(is_mem || opcode == OPC_VEC);
  assign unused_inst_bits = ^{vec_inst[XLEN-1:28], vec_inst[25:15], vec_inst[11:7]};

  // the held mode flags tell which unit owns the completion handshake
  assign unit_done  = (ld_inst || st_inst) ? lsu_done : exec_done;
  assign inst_ready = (state == IDLE);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      last_idx        <= '0;
      reg_grp_idx     <= '0;
      csrwr_en        <= 1'b0;
      ld_inst         <= 1'b0;
      st_inst         <= 1'b0;
      stride_sel      <= 1'b0;
      index_str       <= 1'b0;
      index_unordered <= 1'b0;
      lsu_start       <= 1'b0;
      arith_start     <= 1'b0;
      inst_done       <= 1'b0;
      illegal_inst    <= 1'b0;
    end else begin
      csrwr_en     <= 1'b0;
      lsu_start    <= 1'b0;
      arith_start  <= 1'b0;
      inst_done    <= 1'b0;
      illegal_inst <= 1'b0;
      case (state)
        IDLE: begin
          if (inst_valid) begin
            if (dec_illegal) begin
              illegal_inst <= 1'b1;
            end else if (is_conf) begin
              state    <= CONFIG;
              csrwr_en <= 1'b1;
            end else begin
              state           <= ISSUE;
              reg_grp_idx     <= '0;
              last_idx        <= nregs - CNT_W'(1);
              ld_inst         <= is_load;
              st_inst         <= is_store;
              stride_sel      <= is_mem && (mop == MOP_UNIT);
              index_str       <= is_mem && mop[0];
              index_unordered <= is_mem && (mop == MOP_IDX_UNORD);
              lsu_start       <= is_mem;
              arith_start     <= !is_mem;
            end
          end
        end
        CONFIG: begin
          state     <= DONE;
          inst_done <= 1'b1;
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (unit_done) begin
            if (reg_grp_idx == last_idx) begin
              state     <= DONE;
              inst_done <= 1'b1;
            end else begin
              state       <= ISSUE;
              reg_grp_idx <= reg_grp_idx + CNT_W'(1);
              lsu_start   <= ld_inst || st_inst;
              arith_start <= !(ld_inst || st_inst);
            end
          end
        end
        DONE: begin
          state           <= IDLE;
          reg_grp_idx     <= '0;
          ld_inst         <= 1'b0;
          st_inst         <= 1'b0;
          stride_sel      <= 1'b0;
          index_str       <= 1'b0;
          index_unordered <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_inst_sequencer.sv
// Table-driven bench for vec_inst_sequencer with a start-pulse scoreboard
// and hand-written reset-abort and spurious-done sequences.
module tb_vec_inst_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        inst_valid = 1'b0;
  logic        inst_ready;
  logic [31:0] vec_inst = '0;
  logic [2:0]  vlmul = '0;
  logic        csrwr_en, ld_inst, st_inst, stride_sel, index_str, index_unordered;
  logic        lsu_start, arith_start, busy, inst_done, illegal_inst;
  logic [3:0]  reg_grp_idx;
  logic        lsu_done = 1'b0;
  logic        exec_done = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vec_inst_sequencer dut (
    .clk(clk), .reset(reset), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .vec_inst(vec_inst), .vlmul(vlmul), .csrwr_en(csrwr_en), .ld_inst(ld_inst),
    .st_inst(st_inst), .stride_sel(stride_sel), .index_str(index_str),
    .index_unordered(index_unordered), .lsu_start(lsu_start), .arith_start(arith_start),
    .reg_grp_idx(reg_grp_idx), .lsu_done(lsu_done), .exec_done(exec_done),
    .busy(busy), .inst_done(inst_done), .illegal_inst(illegal_inst)
  );

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  lm;
    int          lat;
    bit          ill, conf, ld, st, stride, idx, unord, spur;
    int          nregs;
  } vec_t;

  typedef struct {
    bit         lsu;
    logic [3:0] idx;
  } start_t;

  start_t sb_q[$];
  vec_t   tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_inst(input vec_t v);
    int cd = 0;
    int ndone = 0;
    int cyc = 0;
    bit mem = v.ld | v.st;
    bit finished = 0;
    if (!v.ill && !v.conf)
      for (int i = 0; i < v.nregs; i++) sb_q.push_back('{lsu: mem, idx: 4'(i)});
    @(negedge clk);
    chk("ready_before_accept", inst_ready, 1);
    inst_valid = 1; vec_inst = v.inst; vlmul = v.lm;
    @(negedge clk);
    inst_valid = 0;
    if (v.ill) begin
      chk("illegal_pulse", illegal_inst, 1);
      chk("illegal_no_start", {lsu_start, arith_start, csrwr_en, busy}, 0);
      chk("illegal_ready", inst_ready, 1);
      @(negedge clk);
      chk("illegal_one_cycle", illegal_inst, 0);
      chk("illegal_no_start2", {lsu_start, arith_start, busy}, 0);
      return;
    end
    if (v.conf) begin
      chk("conf_csrwr", csrwr_en, 1);
      chk("conf_modes", {ld_inst, st_inst, inst_ready, lsu_start, arith_start}, 0);
      @(negedge clk);
      chk("conf_done", {inst_done, csrwr_en}, 2'b10);
      @(negedge clk);
      chk("conf_ready", {inst_ready, inst_done}, 2'b10);
      return;
    end
    cyc = 1;
    while (!finished && cyc < 300) begin
      bit st_seen = lsu_start | arith_start;
      if (st_seen) begin
        if (sb_q.size() == 0) chk("extra_start", 1, 0);
        else begin
          start_t e = sb_q.pop_front();
          chk("start_unit", {lsu_start, arith_start}, e.lsu ? 2'b10 : 2'b01);
          chk("reg_grp_idx", reg_grp_idx, e.idx);
        end
        chk("mode_ctrl", {ld_inst, st_inst, stride_sel, index_str, index_unordered},
            {v.ld, v.st, v.stride, v.idx, v.unord});
      end
      if (inst_done) begin
        ndone++;
        chk("done_latency", cyc, v.nregs * (v.lat + 1) + 1);
        chk("done_busy", busy, 1);
        finished = 1;
      end else if (busy !== 1'b1) begin
        chk("busy_during_inst", busy, 1);
      end
      lsu_done = 0; exec_done = 0;
      if (st_seen) cd = v.lat;
      else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          if (mem) lsu_done = 1; else exec_done = 1;
        end
      end
      if (v.spur && !finished) begin
        if (st_seen) begin
          if (mem) lsu_done = 1; else exec_done = 1;
        end else begin
          if (mem) exec_done = 1; else lsu_done = 1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    lsu_done = 0; exec_done = 0;
    chk("inst_done_seen", ndone, 1);
    chk("starts_consumed", sb_q.size(), 0);
    sb_q.delete();
    chk("after_done_idle", {inst_ready, busy, inst_done, ld_inst, st_inst, stride_sel, index_str},
        7'b1000000);
  endtask

  initial begin
    //            inst          lm      lat ill conf ld st str idx uno spur n
    tbl[0] = '{32'h0C0572D7, 3'b000, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1};
    tbl[1] = '{32'h02028007, 3'b011, 3, 0, 0, 1, 0, 1, 0, 0, 1, 8};
    tbl[2] = '{32'h04028027, 3'b001, 2, 0, 0, 0, 1, 0, 1, 1, 0, 2};
    tbl[3] = '{32'h00000033, 3'b000, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[4] = '{32'h02028007, 3'b100, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[5] = '{32'h02000057, 3'b010, 1, 0, 0, 0, 0, 0, 0, 0, 1, 4};
    tbl[6] = '{32'h08028007, 3'b101, 2, 0, 0, 1, 0, 0, 0, 0, 0, 1};
    tbl[7] = '{32'h0C028027, 3'b000, 4, 0, 0, 0, 1, 0, 1, 0, 0, 1};
    tbl[8] = '{32'h0C0572D7, 3'b100, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};

    repeat (2) @(negedge clk);
    chk("reset_ready", inst_ready, 1);
    chk("reset_outputs", {csrwr_en, ld_inst, st_inst, stride_sel, index_str, index_unordered,
        lsu_start, arith_start, reg_grp_idx, busy, inst_done, illegal_inst}, 0);
    reset = 1;

    // done pulses while idle must be ignored
    @(negedge clk);
    lsu_done = 1;
    @(negedge clk);
    lsu_done = 0; exec_done = 1;
    @(negedge clk);
    exec_done = 0;
    chk("spurious_idle", {busy, lsu_start, arith_start, inst_done, reg_grp_idx}, 0);
    chk("spurious_idle_ready", inst_ready, 1);

    for (int i = 0; i < 9; i++) run_inst(tbl[i]);

    // reset in WAIT of a 4-register load aborts it silently
    @(negedge clk);
    inst_valid = 1; vec_inst = 32'h02028007; vlmul = 3'b010;
    @(negedge clk);
    inst_valid = 0;
    chk("abort_first_start", lsu_start, 1);
    repeat (2) @(negedge clk);
    chk("abort_in_wait", {busy, ld_inst}, 2'b11);
    reset = 0;
    #1;
    chk("abort_outputs", {csrwr_en, ld_inst, st_inst, stride_sel, index_str, index_unordered,
        lsu_start, arith_start, reg_grp_idx, busy, inst_done, illegal_inst}, 0);
    chk("abort_ready", inst_ready, 1);
    @(negedge clk);
    reset = 1;
    begin
      bit seen = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (inst_done || busy || lsu_start) seen = 1;
      end
      chk("abort_no_done", seen, 0);
    end
    run_inst(tbl[1]);
    run_inst(tbl[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
